// File: rtl/adc_seq_ctrl_if.sv
// rtl/adc_seq_ctrl_if.sv - ADC conversion handshake between sequencer and shared ADC
//
// Purpose: bundles the start/address/data-ready/data signals of the shared
// single-port ADC. Suffixes are named from the sequencer's point of view.
// Signals:
//   adc_start_o  one-cycle start-of-conversion pulse (sequencer -> ADC)
//   adc_addr_o   7-bit ADC channel address          (sequencer -> ADC)
//   adc_drdy_i   one-cycle data-ready pulse          (ADC -> sequencer)
//   adc_data_i   16-bit result, valid with adc_drdy_i (ADC -> sequencer)
// Modports: master = sequencer side, slave = ADC side.
interface adc_seq_ctrl_if;
  logic        adc_start_o;
  logic [6:0]  adc_addr_o;
  logic        adc_drdy_i;
  logic [15:0] adc_data_i;

  modport master (
    output adc_start_o,
    output adc_addr_o,
    input  adc_drdy_i,
    input  adc_data_i
  );

  modport slave (
    input  adc_start_o,
    input  adc_addr_o,
    output adc_drdy_i,
    output adc_data_i
  );
endinterface

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - three-channel ADC sequencer with timeout and overrun supervision
//
// Purpose: on each accepted trigger converts ch0, ch1, ch2 in fixed order on the
// shared ADC, captures each result into a shadow register and publishes a
// coherent sample set (ch0, ch1, ch2, v_fc = max(ch0 - ch2, 0)) with a
// one-cycle valid strobe.
// Ports:
//   clk_100m, rst_ni               clock, asynchronous active-low reset
//   enable_i, trig_i               trigger acceptance
//   adc                            ADC handshake (master modport)
//   v_ch0_o..v_ch2_o, v_fc_o       published samples
//   set_valid_o                    strobe: published samples updated this cycle
//   timeout_err_o, overrun_o       sticky supervision flags
//   err_clr_i                      clears both sticky flags (a set event wins)
module adc_seq_ctrl #(
  parameter int unsigned NUM_CH         = 3,
  parameter logic [6:0]  CH0_ADDR       = 7'h17,
  parameter logic [6:0]  CH1_ADDR       = 7'h1E,
  parameter logic [6:0]  CH2_ADDR       = 7'h1F,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_100m,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          trig_i,
  adc_seq_ctrl_if.master adc,
  output logic [15:0]   v_ch0_o,
  output logic [15:0]   v_ch1_o,
  output logic [15:0]   v_ch2_o,
  output logic [15:0]   v_fc_o,
  output logic          set_valid_o,
  output logic          timeout_err_o,
  output logic          overrun_o,
  input  logic          err_clr_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST = 2'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sh0_q, sh0_d, sh1_q, sh1_d;
  logic [6:0]       addr_q, addr_d;
  logic [15:0]      ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d, fc_q, fc_d;
  logic             tout_q, tout_d, ovr_q, ovr_d;
  logic             wait_w, drdy_w, last_w, expire_w;

  function automatic logic [6:0] ch_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    ch_addr = CH0_ADDR;
      2'd1:    ch_addr = CH1_ADDR;
      default: ch_addr = CH2_ADDR;
    endcase
  endfunction

  assign wait_w   = (state_q == ST_WAIT);
  assign drdy_w   = wait_w && adc.adc_drdy_i;
  assign last_w   = (idx_q == IDX_LAST);
  // drdy arriving on the expiry cycle takes priority over the timeout
  assign expire_w = wait_w && !adc.adc_drdy_i && (cnt_q == CNT_LAST);

  // state register
  always_ff @(posedge clk_100m or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (trig_i && enable_i) state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (drdy_w)        state_d = last_w ? ST_PUBLISH : ST_START;
        else if (expire_w) state_d = ST_IDLE;
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    adc.adc_start_o = (state_q == ST_START);
    set_valid_o     = (state_q == ST_PUBLISH);
  end

  // datapath next-state
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    sh0_d = sh0_q;
    sh1_d = sh1_q;
    ch0_d = ch0_q;
    ch1_d = ch1_q;
    ch2_d = ch2_q;
    fc_d  = fc_q;
    case (state_q)
      // counter holds cycles elapsed since the start pulse while in WAIT
      ST_START: cnt_d = CNT_W'(1);
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (adc.adc_drdy_i) begin
          if (idx_q == 2'd0) sh0_d = adc.adc_data_i;
          if (idx_q == 2'd1) sh1_d = adc.adc_data_i;
          if (last_w) begin
            // published set loads on the final drdy edge so it is visible
            // during the PUBLISH cycle together with set_valid_o
            ch0_d = sh0_q;
            ch1_d = sh1_q;
            ch2_d = adc.adc_data_i;
            fc_d  = (sh0_q >= adc.adc_data_i) ? (sh0_q - adc.adc_data_i) : 16'd0;
            idx_d = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (expire_w) begin
          idx_d = 2'd0;
        end
      end
      default: idx_d = 2'd0;
    endcase

    if (state_d == ST_WAIT)       addr_d = addr_q;
    else if (state_d == ST_START) addr_d = ch_addr(idx_d);
    else                          addr_d = CH0_ADDR;

    tout_d = expire_w ? 1'b1 : (err_clr_i ? 1'b0 : tout_q);
    ovr_d  = (trig_i && (state_q != ST_IDLE)) ? 1'b1 : (err_clr_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk_100m or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= 2'd0;
      cnt_q  <= '0;
      sh0_q  <= 16'd0;
      sh1_q  <= 16'd0;
      addr_q <= CH0_ADDR;
      ch0_q  <= 16'd0;
      ch1_q  <= 16'd0;
      ch2_q  <= 16'd0;
      fc_q   <= 16'd0;
      tout_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      sh0_q  <= sh0_d;
      sh1_q  <= sh1_d;
      addr_q <= addr_d;
      ch0_q  <= ch0_d;
      ch1_q  <= ch1_d;
      ch2_q  <= ch2_d;
      fc_q   <= fc_d;
      tout_q <= tout_d;
      ovr_q  <= ovr_d;
    end
  end

  assign adc.adc_addr_o = addr_q;
  assign v_ch0_o        = ch0_q;
  assign v_ch1_o        = ch1_q;
  assign v_ch2_o        = ch2_q;
  assign v_fc_o         = fc_q;
  assign timeout_err_o  = tout_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb/tb_adc_seq_ctrl.sv - scoreboard testbench for adc_seq_ctrl
module tb_adc_seq_ctrl;

  localparam int         TO = 1024;
  localparam logic [6:0] A0 = 7'h17;
  localparam logic [6:0] A1 = 7'h1E;
  localparam logic [6:0] A2 = 7'h1F;

  logic        clk_100m  = 1'b0;
  logic        rst_ni    = 1'b0;
  logic        enable_i  = 1'b0;
  logic        trig_i    = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [15:0] v_ch0_o, v_ch1_o, v_ch2_o, v_fc_o;
  logic        set_valid_o, timeout_err_o, overrun_o;

  adc_seq_ctrl_if bus ();

  adc_seq_ctrl dut (
    .clk_100m      (clk_100m),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .trig_i        (trig_i),
    .adc           (bus),
    .v_ch0_o       (v_ch0_o),
    .v_ch1_o       (v_ch1_o),
    .v_ch2_o       (v_ch2_o),
    .v_fc_o        (v_fc_o),
    .set_valid_o   (set_valid_o),
    .timeout_err_o (timeout_err_o),
    .overrun_o     (overrun_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 clk_100m = ~clk_100m;

  int cyc = 0;
  always @(posedge clk_100m) cyc <= cyc + 1;

  typedef struct { int dly; logic [15:0] data; } rsp_t;
  typedef struct { int cyc; logic [6:0] addr; } start_t;
  typedef struct { int cyc; logic [15:0] c0, c1, c2, fc; } pub_t;

  rsp_t   rsp_q[$];
  start_t exp_start_q[$];
  pub_t   exp_pub_q[$];

  logic [15:0] last0 = 16'd0, last1 = 16'd0, last2 = 16'd0, lastfc = 16'd0;
  int pass_cnt = 0, total_cnt = 0, start_seen = 0, valid_seen = 0;
  int spur_req = 0, spur_done = 0, adc_pend = 0;
  logic [15:0] spur_data = 16'd0, adc_pend_data = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [15:0] fc_ref(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? 16'(a - b) : 16'd0;
  endfunction

  task automatic check_hold(input string name);
    chk({name, "_ch0"}, 32'(v_ch0_o), 32'(last0));
    chk({name, "_ch1"}, 32'(v_ch1_o), 32'(last1));
    chk({name, "_ch2"}, 32'(v_ch2_o), 32'(last2));
    chk({name, "_fc"},  32'(v_fc_o),  32'(lastfc));
  endtask

  task automatic check_reset(input string name);
    check_hold(name);
    chk({name, "_valid"}, 32'(set_valid_o), 32'(0));
    chk({name, "_start"}, 32'(bus.adc_start_o), 32'(0));
    chk({name, "_addr"},  32'(bus.adc_addr_o), 32'(A0));
    chk({name, "_tout"},  32'(timeout_err_o), 32'(0));
    chk({name, "_ovr"},   32'(overrun_o), 32'(0));
  endtask

  // ADC model: answers each start with drdy dly cycles later (dly 0 = never)
  initial begin : adc_model
    rsp_t r;
    bus.adc_drdy_i = 1'b0;
    bus.adc_data_i = 16'd0;
    forever begin
      @(posedge clk_100m); #1;
      bus.adc_drdy_i = 1'b0;
      if (!rst_ni) adc_pend = 0;
      else if (adc_pend > 0) begin
        adc_pend--;
        if (adc_pend == 0) begin
          bus.adc_drdy_i = 1'b1;
          bus.adc_data_i = adc_pend_data;
        end
      end
      if (spur_done != spur_req) begin
        spur_done = spur_req;
        bus.adc_drdy_i = 1'b1;
        bus.adc_data_i = spur_data;
      end
      @(negedge clk_100m);
      if (bus.adc_start_o && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        adc_pend = r.dly;
        adc_pend_data = r.data;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a start or a valid
  initial begin : monitor
    start_t s;
    pub_t   p;
    forever begin
      @(negedge clk_100m);
      if (bus.adc_start_o) begin
        start_seen++;
        chk("start_expected", 32'(exp_start_q.size() != 0), 32'(1));
        if (exp_start_q.size() != 0) begin
          s = exp_start_q.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("start_addr", 32'(bus.adc_addr_o), 32'(s.addr));
        end
      end
      if (set_valid_o) begin
        valid_seen++;
        chk("valid_expected", 32'(exp_pub_q.size() != 0), 32'(1));
        if (exp_pub_q.size() != 0) begin
          p = exp_pub_q.pop_front();
          chk("valid_cycle", cyc, p.cyc);
          chk("pub_ch0", 32'(v_ch0_o), 32'(p.c0));
          chk("pub_ch1", 32'(v_ch1_o), 32'(p.c1));
          chk("pub_ch2", 32'(v_ch2_o), 32'(p.c2));
          chk("pub_fc",  32'(v_fc_o),  32'(p.fc));
          last0 = p.c0; last1 = p.c1; last2 = p.c2; lastfc = p.fc;
        end
      end
    end
  end

  task automatic wait_done(input int bound);
    int n = 0;
    while ((exp_start_q.size() != 0 || exp_pub_q.size() != 0) && n < bound) begin
      @(negedge clk_100m);
      n++;
    end
    chk("seq_complete", 32'(exp_start_q.size() + exp_pub_q.size()), 32'(0));
    exp_start_q.delete();
    exp_pub_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk_100m);
    #1;
  endtask

  // kind: 0 none, 1 drop enable, 2 extra trigger, 3 extra trigger + err_clr
  task automatic run_seq(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                         input int l0, input int l1, input int l2, input int kind, input int off);
    int t, s0, s1, s2;
    rsp_q.push_back(rsp_t'{l0, d0});
    rsp_q.push_back(rsp_t'{l1, d1});
    rsp_q.push_back(rsp_t'{l2, d2});
    @(posedge clk_100m); #1;
    t = cyc;
    trig_i = 1'b1;
    s0 = t + 1;
    s1 = s0 + l0 + 1;
    s2 = s1 + l1 + 1;
    exp_start_q.push_back(start_t'{s0, A0});
    exp_start_q.push_back(start_t'{s1, A1});
    exp_start_q.push_back(start_t'{s2, A2});
    exp_pub_q.push_back(pub_t'{s2 + l2 + 1, d0, d1, d2, fc_ref(d0, d2)});
    @(posedge clk_100m); #1;
    trig_i = 1'b0;
    if (kind != 0) begin
      while (cyc < t + off) begin
        @(posedge clk_100m); #1;
      end
      case (kind)
        1:       enable_i = 1'b0;
        2:       trig_i = 1'b1;
        default: begin trig_i = 1'b1; err_clr_i = 1'b1; end
      endcase
      @(posedge clk_100m); #1;
      trig_i = 1'b0;
      err_clr_i = 1'b0;
    end
    wait_done(3000);
  endtask

  task automatic pulse_clr();
    @(posedge clk_100m); #1;
    err_clr_i = 1'b1;
    @(posedge clk_100m); #1;
    err_clr_i = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : main
    int t, rise, n, sv, vv;
    logic [15:0] a, b, c;

    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    check_reset("reset");
    @(posedge clk_100m); #1;
    rst_ni = 1'b1;
    enable_i = 1'b1;
    repeat (2) @(posedge clk_100m);

    // nominal sequence from the test plan
    run_seq(16'h8000, 16'h4CCE, 16'h1670, 5, 5, 5, 0, 0);
    chk("nominal_ch1", 32'(v_ch1_o), 32'h4CCE);
    chk("nominal_fc", 32'(v_fc_o), 32'h6990);

    // floor case
    run_seq(16'h1000, 16'h0123, 16'h2000, 3, 4, 2, 0, 0);
    chk("floor_fc", 32'(v_fc_o), 32'h0000);

    // randomized sequences
    for (int i = 0; i < 8; i++) begin
      run_seq(16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), 0, 0);
    end

    // drdy exactly on the timeout expiry cycle: drdy wins
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 2, TO - 1, 3, 0, 0);
    chk("coincident_no_tout", 32'(timeout_err_o), 32'(0));

    // timeout on ch1
    a = 16'($urandom);
    rsp_q.push_back(rsp_t'{5, a});
    rsp_q.push_back(rsp_t'{0, 16'h0000});
    @(posedge clk_100m); #1;
    t = cyc;
    trig_i = 1'b1;
    exp_start_q.push_back(start_t'{t + 1, A0});
    exp_start_q.push_back(start_t'{t + 7, A1});
    @(posedge clk_100m); #1;
    trig_i = 1'b0;
    rise = -1;
    for (int i = 0; i < TO + 40; i++) begin
      @(negedge clk_100m);
      if (timeout_err_o) begin
        rise = cyc;
        break;
      end
    end
    chk("timeout_rise_cycle", rise, t + 7 + TO);
    chk("timeout_starts", 32'(exp_start_q.size()), 32'(0));
    check_hold("timeout_hold");
    exp_start_q.delete();
    rsp_q.delete();
    repeat (3) @(posedge clk_100m);
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 4, 6, 3, 0, 0);
    chk("timeout_sticky", 32'(timeout_err_o), 32'(1));
    pulse_clr();
    @(negedge clk_100m);
    chk("timeout_cleared", 32'(timeout_err_o), 32'(0));

    // overrun: extra trigger during ch0 WAIT
    chk("overrun_before", 32'(overrun_o), 32'(0));
    sv = start_seen;
    vv = valid_seen;
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 5, 5, 5, 2, 3);
    chk("overrun_set", 32'(overrun_o), 32'(1));
    chk("overrun_starts", start_seen - sv, 3);
    chk("overrun_valids", valid_seen - vv, 1);
    pulse_clr();
    @(negedge clk_100m);
    chk("overrun_cleared", 32'(overrun_o), 32'(0));
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 5, 5, 5, 3, 3);
    chk("overrun_set_beats_clr", 32'(overrun_o), 32'(1));
    pulse_clr();

    // enable low: trigger ignored, no flag
    @(posedge clk_100m); #1;
    enable_i = 1'b0;
    sv = start_seen;
    trig_i = 1'b1;
    @(posedge clk_100m); #1;
    trig_i = 1'b0;
    repeat (10) @(posedge clk_100m);
    @(negedge clk_100m);
    chk("disabled_no_start", start_seen - sv, 0);
    chk("disabled_no_ovr", 32'(overrun_o), 32'(0));

    // spurious drdy in IDLE
    vv = valid_seen;
    spur_data = 16'($urandom);
    spur_req++;
    repeat (4) @(posedge clk_100m);
    @(negedge clk_100m);
    check_hold("spurious_hold");
    chk("spurious_no_valid", valid_seen - vv, 0);
    @(posedge clk_100m); #1;
    enable_i = 1'b1;

    // enable dropped during ch1 WAIT: sequence still publishes
    run_seq(16'($urandom), 16'($urandom), 16'($urandom), 5, 5, 5, 1, 8);
    enable_i = 1'b1;

    // reset during ch2 WAIT
    vv = valid_seen;
    rsp_q.push_back(rsp_t'{4, 16'($urandom)});
    rsp_q.push_back(rsp_t'{4, 16'($urandom)});
    rsp_q.push_back(rsp_t'{0, 16'h0000});
    @(posedge clk_100m); #1;
    t = cyc;
    trig_i = 1'b1;
    exp_start_q.push_back(start_t'{t + 1, A0});
    exp_start_q.push_back(start_t'{t + 6, A1});
    exp_start_q.push_back(start_t'{t + 11, A2});
    @(posedge clk_100m); #1;
    trig_i = 1'b0;
    n = 0;
    while (exp_start_q.size() != 0 && n < 100) begin
      @(negedge clk_100m);
      n++;
    end
    chk("rst_starts_seen", 32'(exp_start_q.size()), 32'(0));
    repeat (3) @(posedge clk_100m);
    #2;
    rst_ni = 1'b0;
    last0 = 16'd0; last1 = 16'd0; last2 = 16'd0; lastfc = 16'd0;
    @(negedge clk_100m);
    check_reset("mid_reset");
    exp_start_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk_100m);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_100m);
    @(negedge clk_100m);
    chk("mid_reset_no_valid", valid_seen - vv, 0);
    check_hold("after_reset_hold");
    b = 16'($urandom);
    c = 16'($urandom);
    run_seq(c, b, 16'($urandom), 3, 3, 3, 0, 0);

    chk("final_queues", 32'(exp_start_q.size() + exp_pub_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
